// File: rtl/flash_bist_seq.sv
// Multi-pass flash write/read-back BIST sequencer driving the flash_write and flash_read engines.
// Optional watchdog on WRITE/READ phases enabled by defining FLASH_BIST_TIMEOUT_EN.
module flash_bist_seq #(
  parameter int                DATA_BYTES  = 64,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                NUM_PASSES  = 4,
  parameter int                DELAY_CYC   = 250000,
  parameter int                MAX_RETRY   = 3,
  parameter int                TIMEOUT_CYC = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        seed,
  output logic              busy,
  output logic              pass_done,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       err_cnt,
  output logic              mismatch,
  output logic [7:0]        mism_idx,
  output logic              fail,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ready,
  output logic [7:0]        wr_data,
  output logic              wr_data_vld,
  input  logic              wr_done,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  input  logic              rd_data_vld,
  input  logic              rd_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_WRITE, S_READ, S_CHECK, S_HALT
  } state_e;

  localparam int DLY_W = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((DELAY_CYC > 0) ? DELAY_CYC - 1 : 0);
  localparam logic [8:0]        LAST_IDX  = 9'(DATA_BYTES - 1);
  localparam logic [8:0]        N_BYTES   = 9'(DATA_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_BYTES);

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [8:0]        wr_idx_q, wr_idx_d;
  logic [8:0]        rd_idx_q, rd_idx_d;
  logic [7:0]        seed_q, seed_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d, pass_cnt_inc;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              fail_q, fail_d;
  logic              mismatch_q, mismatch_d;
  logic [7:0]        mism_idx_q, mism_idx_d;
  logic              pass_done_q, pass_done_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_data_vld_q, wr_data_vld_d;

`ifdef FLASH_BIST_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            wdog_hit;
  assign wdog_hit = (wdog_q == TO_LAST);
`endif

  // Page pattern: byte i of pass p is seed + i + p (mod 256).
  function automatic logic [7:0] pattern(input logic [7:0] s, input logic [7:0] idx,
                                         input logic [7:0] pc);
    return s + idx + pc;
  endfunction

  assign pass_cnt_inc = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;

  // NOTE: every *_d gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    dly_cnt_d     = dly_cnt_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    seed_d        = seed_q;
    pass_cnt_d    = pass_cnt_q;
    err_cnt_d     = err_cnt_q;
    retry_d       = retry_q;
    addr_d        = addr_q;
    wr_addr_d     = wr_addr_q;
    fail_d        = fail_q;
    mism_idx_d    = mism_idx_q;
    wr_data_d     = wr_data_q;
    mismatch_d    = 1'b0;
    pass_done_d   = 1'b0;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    wr_data_vld_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d    = S_DELAY;
          seed_d     = seed;
          pass_cnt_d = '0;
          err_cnt_d  = '0;
          fail_d     = 1'b0;
          retry_d    = '0;
          addr_d     = BASE_ADDR;
          dly_cnt_d  = '0;
        end
      end

      S_DELAY: begin
        if (dly_cnt_q == DLY_LAST) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_idx_d  = '0;
          dly_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end

      S_WRITE: begin
        if (wr_ready) begin
          wr_data_d     = pattern(seed_q, wr_idx_q[7:0], pass_cnt_q[7:0]);
          wr_data_vld_d = 1'b1;
          // Requests past the page end keep re-sending the last byte.
          if (wr_idx_q < LAST_IDX) wr_idx_d = wr_idx_q + 9'd1;
        end
        if (wr_err) begin
          if (int'(retry_q) < MAX_RETRY) begin
            retry_d   = retry_q + RTY_W'(1);
            state_d   = S_DELAY;
            dly_cnt_d = '0;
            wr_idx_d  = '0;
          end else begin
            fail_d  = 1'b1;
            state_d = S_HALT;
          end
        end else if (wr_done) begin
          state_d  = S_READ;
          rd_en_d  = 1'b1;
          rd_idx_d = '0;
        end
`ifdef FLASH_BIST_TIMEOUT_EN
        else if (wdog_hit) begin
          fail_d  = 1'b1;
          state_d = S_HALT;
        end
`endif
      end

      S_READ: begin
        if (rd_data_vld && (rd_idx_q < N_BYTES)) begin
          if (rd_data != pattern(seed_q, rd_idx_q[7:0], pass_cnt_q[7:0])) begin
            mismatch_d = 1'b1;
            mism_idx_d = rd_idx_q[7:0];
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          end
          rd_idx_d = rd_idx_q + 9'd1;
        end
        if (rd_done) begin
          state_d     = S_CHECK;
          pass_done_d = 1'b1;
        end
`ifdef FLASH_BIST_TIMEOUT_EN
        else if (wdog_hit) begin
          fail_d  = 1'b1;
          state_d = S_HALT;
        end
`endif
      end

      S_CHECK: begin
        pass_cnt_d = pass_cnt_inc;
        retry_d    = '0;
        addr_d     = addr_q + ADDR_STEP;
        if (stop || ((NUM_PASSES != 0) && (int'(pass_cnt_inc) == NUM_PASSES))) begin
          state_d = S_HALT;
        end else begin
          state_d   = S_DELAY;
          dly_cnt_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef FLASH_BIST_TIMEOUT_EN
  always_comb begin
    wdog_d = '0;
    if ((state_d == state_q) && ((state_q == S_WRITE) || (state_q == S_READ)))
      wdog_d = wdog_q + TO_W'(1);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      dly_cnt_q     <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      seed_q        <= '0;
      pass_cnt_q    <= '0;
      err_cnt_q     <= '0;
      retry_q       <= '0;
      addr_q        <= BASE_ADDR;
      wr_addr_q     <= '0;
      fail_q        <= 1'b0;
      mismatch_q    <= 1'b0;
      mism_idx_q    <= '0;
      pass_done_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      wr_data_q     <= '0;
      wr_data_vld_q <= 1'b0;
`ifdef FLASH_BIST_TIMEOUT_EN
      wdog_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      dly_cnt_q     <= dly_cnt_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      seed_q        <= seed_d;
      pass_cnt_q    <= pass_cnt_d;
      err_cnt_q     <= err_cnt_d;
      retry_q       <= retry_d;
      addr_q        <= addr_d;
      wr_addr_q     <= wr_addr_d;
      fail_q        <= fail_d;
      mismatch_q    <= mismatch_d;
      mism_idx_q    <= mism_idx_d;
      pass_done_q   <= pass_done_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      wr_data_q     <= wr_data_d;
      wr_data_vld_q <= wr_data_vld_d;
`ifdef FLASH_BIST_TIMEOUT_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign pass_done   = pass_done_q;
  assign pass_cnt    = pass_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign mismatch    = mismatch_q;
  assign mism_idx    = mism_idx_q;
  assign fail        = fail_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign rd_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_data_vld = wr_data_vld_q;
  assign rd_en       = rd_en_q;

endmodule

// File: tb/tb_flash_bist_seq.sv
// Self-checking bench for flash_bist_seq: a behavioural flash engine plus a pattern/address
// reference model computed from seed, byte index and pass number.
module tb_flash_bist_seq;

  localparam int         N      = 4;
  localparam int         AW     = 8;
  localparam logic [7:0] BASE   = 8'hFC;
  localparam int         NPASS  = 2;
  localparam int         DLY    = 5;
  localparam int         RETRY  = 3;
  localparam int         TO_CYC = 100;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [7:0]    seed;
  logic          busy, pass_done, mismatch, fail;
  logic [15:0]   pass_cnt, err_cnt;
  logic [7:0]    mism_idx;
  logic          wr_en, wr_ready, wr_data_vld, wr_done, wr_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data, rd_data;
  logic          rd_en, rd_data_vld, rd_done;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] cur_seed;

  always #5 clk = ~clk;

  flash_bist_seq #(
    .DATA_BYTES(N), .ADDR_W(AW), .BASE_ADDR(BASE), .NUM_PASSES(NPASS),
    .DELAY_CYC(DLY), .MAX_RETRY(RETRY), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed),
    .busy(busy), .pass_done(pass_done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
    .mismatch(mismatch), .mism_idx(mism_idx), .fail(fail),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_data_vld(wr_data_vld), .wr_done(wr_done), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .rd_done(rd_done)
  );

  function automatic logic [7:0] exp_byte(input logic [7:0] s, input int i, input int p);
    return 8'((int'(s) + i + p) % 256);
  endfunction

  function automatic logic [7:0] exp_addr(input int p);
    return 8'((int'(BASE) + p * N) % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] s);
    seed = s;
    cur_seed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, pass_cnt, err_cnt, fail} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL start_state: busy/pass_cnt/err_cnt/fail got %b/%0d/%0d/%b want 1/0/0/0",
               busy, pass_cnt, err_cnt, fail);
    end
  endtask

  task automatic wait_wr_en(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < DLY + 20; c++) begin
      tick();
      if (wr_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wr_en_wait: got no wr_en want wr_en within %0d cycles", DLY + 20);
    end
  endtask

  // Issue n_req byte requests; requests past the page end must repeat the last byte.
  task automatic engine_write(input int p, input int n_req);
    logic [7:0] exp;
    int gap;
    for (int k = 0; k < n_req; k++) begin
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      exp = exp_byte(cur_seed, (k < N) ? k : N - 1, p);
      vectors++;
      if (wr_data_vld !== 1'b1 || wr_data !== exp) begin
        miscompares++;
        $display("FAIL wr_byte p%0d k%0d: got vld=%b data=%h want vld=1 data=%h",
                 p, k, wr_data_vld, wr_data, exp);
      end
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) tick();
        vectors++;
        if (wr_data_vld !== 1'b0) begin
          miscompares++;
          $display("FAIL wr_vld_pulse p%0d k%0d: got %b want 0", p, k, wr_data_vld);
        end
      end
    end
  endtask

  // One full pass: n_err write errors before success, optional flipped read byte.
  task automatic engine_pass(input int p, input int n_err, input int flip, input bit done_last);
    bit ok;
    logic [7:0] mask;
    for (int a = 0; a <= n_err; a++) begin
      wait_wr_en(ok);
      if (!ok) return;
      vectors++;
      if (wr_addr !== exp_addr(p)) begin
        miscompares++;
        $display("FAIL wr_addr p%0d: got %h want %h", p, wr_addr, exp_addr(p));
      end
      if (a < n_err) begin
        engine_write(p, 2);
        wr_err  = 1'b1;
        wr_done = (a == 0);
        tick();
        wr_err  = 1'b0;
        wr_done = 1'b0;
        vectors++;
        if ({rd_en, busy, fail} !== 3'b010) begin
          miscompares++;
          $display("FAIL retry p%0d a%0d: rd_en/busy/fail got %b want 010", p, a, {rd_en, busy, fail});
        end
      end else begin
        engine_write(p, N + 1);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        vectors++;
        if (rd_en !== 1'b1 || rd_addr !== exp_addr(p)) begin
          miscompares++;
          $display("FAIL rd_start p%0d: got rd_en=%b rd_addr=%h want 1 %h", p, rd_en, rd_addr, exp_addr(p));
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      mask = 8'h01 << $urandom_range(0, 7);
      rd_data     = exp_byte(cur_seed, i, p) ^ ((i == flip) ? mask : 8'h00);
      rd_data_vld = 1'b1;
      rd_done     = done_last && (i == N - 1);
      tick();
      rd_data_vld = 1'b0;
      rd_done     = 1'b0;
      vectors++;
      if (mismatch !== (i == flip) || (i == flip && mism_idx !== 8'(i))) begin
        miscompares++;
        $display("FAIL cmp p%0d i%0d: got mismatch=%b mism_idx=%0d want %b %0d",
                 p, i, mismatch, mism_idx, (i == flip), i);
      end
      if (!(done_last && i == N - 1)) repeat ($urandom_range(0, 1)) tick();
    end
    if (!done_last) begin
      rd_data     = ~exp_byte(cur_seed, 0, p);
      rd_data_vld = 1'b1;
      tick();
      rd_data_vld = 1'b0;
      vectors++;
      if (mismatch !== 1'b0) begin
        miscompares++;
        $display("FAIL extra_byte p%0d: got mismatch=%b want 0", p, mismatch);
      end
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
    end
    vectors++;
    if (pass_done !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_done p%0d: got %b want 1", p, pass_done);
    end
    tick();
    vectors++;
    if (pass_done !== 1'b0 || pass_cnt !== 16'(p + 1)) begin
      miscompares++;
      $display("FAIL pass_cnt p%0d: got pass_done=%b pass_cnt=%0d want 0 %0d", p, pass_done, pass_cnt, p + 1);
    end
  endtask

  task automatic check_end(input string name, input logic [15:0] exp_err, input logic [15:0] exp_pass);
    vectors++;
    if ({busy, fail, err_cnt, pass_cnt} !== {1'b0, 1'b0, exp_err, exp_pass}) begin
      miscompares++;
      $display("FAIL %s_end: busy/fail/err_cnt/pass_cnt got %b/%b/%0d/%0d want 0/0/%0d/%0d",
               name, busy, fail, err_cnt, pass_cnt, exp_err, exp_pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, pass_done, pass_cnt, err_cnt, mismatch, mism_idx, fail} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 0", {busy, pass_done, pass_cnt, err_cnt, mismatch, mism_idx, fail});
    end
    vectors++;
    if ({wr_en, wr_addr, wr_data, wr_data_vld, rd_en, rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_engine_if: got %h want 0", {wr_en, wr_addr, wr_data, wr_data_vld, rd_en, rd_addr});
    end
  endtask

  task automatic test_basic_run();
    do_start(8'h10);
    seed  = 8'hEE;
    start = 1'b1;
    tick();
    start = 1'b0;
    engine_pass(0, 0, -1, 1'b1);
    engine_pass(1, 0, -1, 1'b0);
    check_end("basic", 16'd0, 16'd2);
    repeat (10) tick();
    vectors++;
    if ({busy, pass_cnt, wr_en} !== {1'b0, 16'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL halt_hold: busy/pass_cnt/wr_en got %b/%0d/%b want 0/2/0", busy, pass_cnt, wr_en);
    end
  endtask

  task automatic test_corrupt();
    do_start(8'($urandom));
    engine_pass(0, 0, 2, $urandom_range(0, 1));
    engine_pass(1, 0, -1, $urandom_range(0, 1));
    check_end("corrupt", 16'd1, 16'd2);
    vectors++;
    if (mism_idx !== 8'd2) begin
      miscompares++;
      $display("FAIL corrupt_idx: got %0d want 2", mism_idx);
    end
  endtask

  task automatic test_retry_clear();
    do_start(8'($urandom));
    engine_pass(0, 2, $urandom_range(0, N - 1), $urandom_range(0, 1));
    engine_pass(1, RETRY, -1, $urandom_range(0, 1));
    check_end("retry_clear", 16'd1, 16'd2);
  endtask

  task automatic test_write_fail();
    bit ok;
    int seen;
    do_start(8'($urandom));
    for (int a = 0; a <= RETRY; a++) begin
      wait_wr_en(ok);
      wr_err = 1'b1;
      tick();
      wr_err = 1'b0;
      vectors++;
      if ({fail, busy} !== ((a < RETRY) ? 2'b01 : 2'b10)) begin
        miscompares++;
        $display("FAIL wr_err a%0d: fail/busy got %b want %b", a, {fail, busy}, (a < RETRY) ? 2'b01 : 2'b10);
      end
    end
    seen = 0;
    for (int c = 0; c < 3 * DLY; c++) begin
      tick();
      if (wr_en === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0 || fail !== 1'b1) begin
      miscompares++;
      $display("FAIL fail_halt: got wr_en_count=%0d fail=%b want 0 1", seen, fail);
    end
  endtask

  task automatic test_stop();
    do_start(8'($urandom));
    stop = 1'b1;
    engine_pass(0, 0, -1, $urandom_range(0, 1));
    stop = 1'b0;
    check_end("stop", 16'd0, 16'd1);
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    do_start(8'($urandom));
    wait_wr_en(ok);
    engine_write(0, N);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd_data     = exp_byte(cur_seed, i, 0) ^ ((i == 1) ? 8'h80 : 8'h00);
      rd_data_vld = 1'b1;
      tick();
      rd_data_vld = 1'b0;
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({busy, pass_done, pass_cnt, err_cnt, mismatch, mism_idx, fail, wr_en, wr_addr,
         wr_data, wr_data_vld, rd_en, rd_addr} !== '0) begin
      miscompares++;
      $display("FAIL mid_read_reset: got busy=%b err_cnt=%0d mism_idx=%0d wr_addr=%h want all 0",
               busy, err_cnt, mism_idx, wr_addr);
    end
    rst = 1'b0;
    tick();
    do_start(8'($urandom));
    engine_pass(0, 0, -1, $urandom_range(0, 1));
    engine_pass(1, 0, -1, $urandom_range(0, 1));
    check_end("after_reset", 16'd0, 16'd2);
  endtask

  task automatic test_timeout();
    bit ok;
    do_start(8'($urandom));
    wait_wr_en(ok);
    engine_write(0, N);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    repeat (TO_CYC + 50) tick();
    vectors++;
`ifdef FLASH_BIST_TIMEOUT_EN
    if ({fail, busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL read_timeout: fail/busy got %b want 10", {fail, busy});
    end
`else
    if ({fail, busy, pass_done} !== 3'b010) begin
      miscompares++;
      $display("FAIL read_wait: fail/busy/pass_done got %b want 010", {fail, busy, pass_done});
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; seed = '0; cur_seed = '0;
    wr_ready = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
    rd_data = '0; rd_data_vld = 1'b0; rd_done = 1'b0;
    test_reset();
    test_basic_run();
    test_corrupt();
    test_retry_clear();
    test_write_fail();
    test_stop();
    test_reset_mid_read();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test want completion within 2 ms");
    $fatal(1, "bench did not finish");
  end

endmodule
